// File: rtl/ram_bubble_sorter.sv
// In-place ascending bubble sort of a single-port RAM with early exit.
// Moore FSM; every output is a register loaded alongside the next state.
module ram_bubble_sorter #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wren,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  swaps
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_CMP,
        S_WR_A,
        S_WR_B,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_i;
    logic [ADDR_W-1:0]   r_limit;
    logic                r_swapped;
    logic [DATA_W-1:0]   r_a;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_wren;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_swaps;

    logic [ADDR_W-1:0]   w_i_inc;

    // i+1 never exceeds DEPTH-1, so it always fits in ADDR_W bits.
    assign w_i_inc = r_i + ONE;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_i       <= '0;
            r_limit   <= LAST;
            r_swapped <= 1'b0;
            r_a       <= '0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_wren    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_swaps   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_addr <= '0;
                    r_wren <= 1'b0;
                    if (start) begin
                        r_i       <= '0;
                        r_limit   <= LAST;
                        r_swapped <= 1'b0;
                        r_swaps   <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RD_A;
                    end
                end

                S_RD_A: begin
                    r_addr  <= w_i_inc;
                    r_state <= S_RD_B;
                end

                S_RD_B: begin
                    r_a     <= rd_data;
                    r_state <= S_CMP;
                end

                S_CMP: begin
                    // Strict compare: equal neighbours are left untouched.
                    if (r_a > rd_data) begin
                        r_addr    <= r_i;
                        r_wr_data <= rd_data;
                        r_wren    <= 1'b1;
                        r_state   <= S_WR_A;
                    end else begin
                        r_state <= S_NEXT;
                    end
                end

                S_WR_A: begin
                    r_addr    <= w_i_inc;
                    r_wr_data <= r_a;
                    r_wren    <= 1'b1;
                    r_state   <= S_WR_B;
                end

                S_WR_B: begin
                    r_wren    <= 1'b0;
                    r_swapped <= 1'b1;
                    if (r_swaps != {CNT_W{1'b1}}) begin
                        r_swaps <= r_swaps + 1'b1;
                    end
                    r_state <= S_NEXT;
                end

                S_NEXT: begin
                    if (w_i_inc != r_limit) begin
                        r_i     <= w_i_inc;
                        r_addr  <= w_i_inc;
                        r_state <= S_RD_A;
                    end else if (!r_swapped || r_limit == ONE) begin
                        r_addr  <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        // The largest remaining word has settled at limit.
                        r_limit   <= r_limit - ONE;
                        r_i       <= '0;
                        r_swapped <= 1'b0;
                        r_addr    <= '0;
                        r_state   <= S_RD_A;
                    end
                end

                S_DONE: begin
                    r_wren <= 1'b0;
                    if (!start) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_wren  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign addr    = r_addr;
    assign wr_data = r_wr_data;
    assign wren    = r_wren;
    assign busy    = r_busy;
    assign done    = r_done;
    assign swaps   = r_swaps;

endmodule

// File: tb/tb_ram_bubble_sorter.sv
// Directed bench for ram_bubble_sorter: array-level reference sort, per-cycle
// busy/done checker, and literal pins for the canonical scenarios.
module tb_ram_bubble_sorter;

    typedef logic [7:0] ram_t [32];

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] rd_data;
    logic [4:0] addr;
    logic [7:0] wr_data;
    logic       wren;
    logic       busy;
    logic       done;
    logic [9:0] swaps;

    ram_bubble_sorter dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .rd_data (rd_data),
        .addr    (addr),
        .wr_data (wr_data),
        .wren    (wren),
        .busy    (busy),
        .done    (done),
        .swaps   (swaps)
    );

    always #5 clk = ~clk;

    // RAM with a bench load port used only while the sorter is idle.
    logic [7:0] mem [32];
    logic       ld_en = 1'b0;
    logic [4:0] ld_addr = '0;
    logic [7:0] ld_data = '0;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (wren) mem[addr] <= wr_data;
        rd_data <= mem[addr];
    end

    int wr_count = 0;
    always @(posedge clk) if (wren) wr_count <= wr_count + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Edge counter: 0 right after the edge that samples start.
    logic chk_on = 1'b0;
    int   exp_t  = 0;
    int   edge_n = -1;
    always @(posedge clk) edge_n <= chk_on ? edge_n + 1 : -1;

    always @(negedge clk) begin
        if (chk_on && edge_n >= 0) begin
            if (edge_n < exp_t) begin
                check("busy_during_sort", int'(busy), 1);
                check("done_during_sort", int'(done), 0);
            end else begin
                check("done_after_sort", int'(done), 1);
                check("busy_after_sort", int'(busy), 0);
                check("wren_after_sort", int'(wren), 0);
            end
        end
    end

    // Reference: bubble sort with early exit on a plain array, costing
    // 4 cycles per compare plus 2 per swap.
    task automatic model(input ram_t d, output int t, output int sw, output ram_t s);
        int   lim;
        logic any;
        logic [7:0] tmp;
        s = d; t = 0; sw = 0; lim = 31;
        forever begin
            any = 1'b0;
            for (int j = 0; j < lim; j++) begin
                t += 4;
                if (s[j] > s[j+1]) begin
                    tmp = s[j]; s[j] = s[j+1]; s[j+1] = tmp;
                    t += 2; sw++; any = 1'b1;
                end
            end
            if (!any || lim == 1) break;
            lim--;
        end
    endtask

    ram_t pat;

    task automatic load_ram();
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = 5'(k); ld_data = pat[k];
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic run_sort(input string nm, input int pin_t, input int pin_sw);
        int   t, sw, wbase, bad_words;
        ram_t s;
        model(pat, t, sw, s);
        if (pin_t >= 0) check({nm, "_model_cycles"}, t, pin_t);
        if (pin_sw >= 0) check({nm, "_model_swaps"}, sw, pin_sw);
        load_ram();
        wbase = wr_count;
        @(negedge clk);
        exp_t = t;
        start = 1'b1;
        chk_on = 1'b1;
        for (int c = 0; c < t + 20 && !done; c++) @(negedge clk);
        check({nm, "_done_seen"}, int'(done), 1);
        check({nm, "_done_edge"}, edge_n, t);
        check({nm, "_swaps"}, int'(swaps), sw);
        check({nm, "_writes"}, wr_count - wbase, 2 * sw);
        bad_words = 0;
        for (int k = 0; k < 32; k++) begin
            if (mem[k] !== s[k]) begin
                bad_words++;
                if (bad_words == 1)
                    $display("FAIL %s_ram: word %0d got %02h expected %02h", nm, k, mem[k], s[k]);
            end
        end
        n_cmp++;
        if (bad_words != 0) n_bad++;
        // start held through DONE must not restart; checker watches it.
        repeat (10) @(negedge clk);
        check({nm, "_swaps_hold"}, int'(swaps), sw);
        start = 1'b0;
        chk_on = 1'b0;
        @(negedge clk);
        check({nm, "_idle_done"}, int'(done), 0);
        check({nm, "_idle_busy"}, int'(busy), 0);
        $display("sort %-10s cycles=%0d swaps=%0d writes=%0d ram_bad=%0d",
                 nm, edge_n, swaps, wr_count - wbase, bad_words);
    endtask

    task automatic set_pat(input int kind);
        for (int k = 0; k < 32; k++) begin
            case (kind)
                0: pat[k] = 8'(k);
                1: pat[k] = 8'(31 - k);
                2: pat[k] = (k == 0) ? 8'd1 : (k == 1) ? 8'd0 : 8'(k);
                default: pat[k] = (k == 31) ? 8'h00 : 8'hFF;
            endcase
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_wren", int'(wren), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_swaps", int'(swaps), 0);
        reset = 1'b1;
        @(negedge clk);

        set_pat(0); run_sort("sorted", 124, 0);
        set_pat(1); run_sort("reverse", 2976, 496);
        set_pat(2); run_sort("pair", 246, 1);
        set_pat(3); run_sort("dups", -1, 31);
        check("dups_low_word", int'(mem[0]), 8'h00);
        check("dups_high_word", int'(mem[31]), 8'hFF);

        // Reset lands on edge 100 of a reverse sort.
        set_pat(1);
        load_ram();
        @(negedge clk);
        start = 1'b1;
        repeat (100) @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_wren", int'(wren), 0);
        check("midrst_swaps", int'(swaps), 0);
        $display("reset mid-sort at edge 100: busy=%0d done=%0d swaps=%0d", busy, done, swaps);
        reset = 1'b1;
        @(negedge clk);
        set_pat(1); run_sort("rev_again", 2976, 496);
        set_pat(0); run_sort("sorted2", 124, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_bubble_sorter.md
Name: ram_bubble_sorter

Overview:
- Sorts the contents of the 32x8 single-port RAM into ascending order in place.
- Uses bubble sort with early exit.
- Sits directly upstream of the binary-search stage, which requires ascending RAM contents. The search stage's start is gated by this block's done.
- Owns the RAM port while busy=1.

Parameters:
- DEPTH, 32, number of RAM words sorted (addresses 0..DEPTH-1); legal range 2..2^ADDR_W.
- ADDR_W, 5, RAM address width.
- DATA_W, 8, RAM word width; values compared as unsigned.
- CNT_W, 10, width of swap counter; must hold DEPTH*(DEPTH-1)/2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low; 0 sampled on a rising edge resets the block.
- start  input  1  level request to sort; sampled only in IDLE.
- rd_data  input  DATA_W  RAM read data; valid the cycle after addr is presented (1-cycle synchronous read).
- addr  output  ADDR_W  RAM address.
- wr_data  output  DATA_W  RAM write data.
- wren  output  1  RAM write enable.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  high only in DONE.
- swaps  output  CNT_W  number of swaps performed in the current or last sort.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE; busy=0, done=0, wren=0, addr=0, wr_data=0, swaps=0.
  - Internal i=0, limit=DEPTH-1, swapped=0.
- Outputs are decoded from state and registers only (Moore); no combinational path from start to outputs.
- IDLE: addr=0, wren=0. If start=1, then i<=0, limit<=DEPTH-1, swapped<=0, swaps<=0, and go to RD_A.
- RD_A: addr=i. Next state RD_B.
- RD_B: addr=i+1; a_reg<=rd_data (word i). Next state CMP.
- CMP:
  - rd_data holds word i+1.
  - If a_reg > rd_data (strictly greater), then b_reg<=rd_data and go to WR_A.
  - Otherwise go to NEXT. Equal values are never swapped.
- WR_A: addr=i, wr_data=b_reg, wren=1. Next state WR_B.
- WR_B: addr=i+1, wr_data=a_reg, wren=1; swapped<=1, swaps<=swaps+1. Next state NEXT.
- NEXT:
  - If i+1 != limit, then i<=i+1 and go to RD_A.
  - Otherwise the pass has ended:
    - If swapped=0 or limit=1, go to DONE.
    - Else limit<=limit-1, i<=0, swapped<=0, and go to RD_A.
- DONE: done=1, busy=0, wren=0. Stay while start=1; go to IDLE when start=0. swaps holds its value in DONE and IDLE until the next accepted start.
- Cycle cost:
  - Non-swap compare: 4 cycles (RD_A, RD_B, CMP, NEXT).
  - Swap compare: 6 cycles.
  - The edge that samples start in IDLE is edge 0; done rises after the edge that leaves the final NEXT.
- wren is asserted only in WR_A and WR_B; at most one write per cycle.
- start changes while busy are ignored. start held high after DONE does not restart the sort; start must return to 0 first.
- Reset mid-operation:
  - Returns to IDLE on that edge; no further writes.
  - RAM contents are left as-is. If reset lands between WR_A and WR_B, word i+1 is not updated and the contents are no longer a permutation of the input.
  - The caller must reload the RAM after any mid-sort reset.
- Width rules: i and limit are ADDR_W bits; i+1 never exceeds DEPTH-1; swaps saturates at the CNT_W max (not reachable with defaults: max is 496).

Test Plan:
- Already sorted RAM[k]=k, k=0..31; start=1 at edge 0 -> no write ever asserted; done=1 after edge 124; swaps=0; RAM unchanged.
- Reverse sorted RAM[k]=31-k -> 31 passes, swaps=496; done=1 after edge 2976 (496*6); RAM[k]=k afterwards.
- One misplaced pair: RAM[k]=k except RAM[0]=1, RAM[1]=0:
  - Pass 1: 1 swap, 31 compares.
  - Pass 2: no swaps, exits early.
  - swaps=1; done after edge 6+30*4+30*4=246; RAM[k]=k.
- Duplicates: RAM all 8'hFF except RAM[31]=8'h00 -> swaps=31, RAM[0]=8'h00, RAM[1..31]=8'hFF; equal neighbours never written.
- Reset mid-sort: reverse-sorted RAM, reset=0 at edge 100 -> next cycle state IDLE, busy=0, done=0, wren=0, swaps=0. Then reload the reverse data, start again -> identical result to the reverse-sorted scenario.
- Handshake: hold start=1 through DONE for 10 cycles -> done stays 1, no restart. Drop start -> IDLE next edge. Pulse start again with sorted RAM -> done after 124 edges, swaps=0.
